cpu_exec_sequencer: RTL and testbench
=====================================

// Module: cpu_exec_sequencer
// PURPOSE
//  Drives exec_enable of the CPU control FSM to sequence instruction execution.
//  Supports free-running RUN at a programmable issue period, single STEP, HALT,
//  and a PC-match breakpoint. Also keeps a retired-instruction counter.
//  Sits between the debug/top-level controls and the fetch/exec FSM.
// PARAMETERS
//  PC_W      8   width of pc_i and bp_addr_i
//  PERIOD_W  8   width of period_i
//  CNT_W     16  width of instr_cnt_o
// PORTS
//  clk_i        in   1         single clock, rising edge
//  rst_i        in   1         synchronous reset, active-high
//  run_i        in   1         level; run request
//  step_i       in   1         1-cycle pulse; execute one instruction
//  halt_i       in   1         1-cycle pulse; stop after the current instruction
//  period_i     in   PERIOD_W  issue-to-issue spacing in clk cycles (0,1 => 2)
//  pc_i         in   PC_W      current program counter
//  bp_en_i      in   1         breakpoint enable
//  bp_addr_i    in   PC_W      breakpoint PC: stop BEFORE executing it
//  cnt_clr_i    in   1         clear instr_cnt_o
//  exec_enable_o out 1         to ctrl FSM; high exactly 1 cycle per instruction
//  busy_o       out  1         high in ISSUE/WAIT
//  bp_hit_o     out  1         high while in BREAK
//  instr_cnt_o  out  CNT_W     instructions issued, wraps
// BEHAVIOUR
//  Reset: state=IDLE, exec_enable_o=0, busy_o=0, bp_hit_o=0, instr_cnt_o=0,
//   run_q=0, run_arm=0, wait counter=0. Reset wins over every other input.
//  eff_period = (period_i<2) ? 2 : period_i, sampled in ISSUE.
//  run_arm: set on a run_i rise (run_i & ~run_q); cleared by halt_i or run_i==0.
//   Halt clear has priority over the rise set.
//  bp_match = bp_en_i & (pc_i==bp_addr_i).
//  go_run = run_i & (run_arm | (run_i & ~run_q)) & ~halt_i.
//  States (exec_enable_o = state==ISSUE; all outputs are registered-state decode):
//   IDLE : go_run & bp_match -> BREAK; go_run -> ISSUE (single=0);
//          else step_i & ~halt_i -> ISSUE (single=1). Run wins over step.
//   ISSUE: 1 cycle; instr_cnt++; wait counter <= eff_period-2 -> WAIT.
//   WAIT : counter>0 -> decrement, stay. At counter==0 (decision cycle):
//          single | halt_pend | ~run_arm -> IDLE;
//          bp_match -> BREAK; else -> ISSUE.
//   BREAK: step_i -> ISSUE (single=1); run_i==0 -> IDLE; else stay.
//  Timing: a go/step decision at edge k puts exec_enable_o high in cycle k+1.
//   Issue spacing is exactly eff_period cycles: 1 high, >=1 low, which satisfies
//   the FSM rising-edge detect. pc_i is used only in decision cycles, at least 1
//   cycle after the issue.
//  halt_pend: set by halt_i in ISSUE/WAIT; cleared on entry to IDLE. WAIT is
//   never truncated. The in-flight instruction completes, then no more issues
//   until run_i falls and rises again, or step_i.
//  step_i in ISSUE/WAIT is ignored. halt_i+step_i together in IDLE: halt wins,
//   no issue.
//  After a step out of BREAK, PC has moved past bp_addr, so an armed run resumes
//   from IDLE.
//  instr_cnt_o: cnt_clr_i forces 0 and wins over a same-cycle increment;
//   2^CNT_W-1 + 1 wraps to 0.
//  Reset mid-ISSUE/WAIT: exec_enable_o=0 next cycle. If run_i is held high, run
//   restarts after reset, because run_q resets to 0.
// TESTING
//  1. period=4, run_i 0->1 sampled at edge 0 -> exec_enable_o high cycles 1,5,9;
//     instr_cnt_o=3 after cycle 9.
//  2. period=0 and period=1 -> pulses every 2 cycles (1 high, 1 low);
//     period=255 -> spacing 255.
//  3. Idle, step_i pulse, period=5 -> exactly one pulse, busy_o high 5 cycles,
//     back to IDLE, cnt +1.
//  4. bp_en=1, bp_addr=3, PC increments per issue from 0, run -> 3 pulses,
//     bp_hit_o=1, no more pulses. step_i -> 1 pulse, bp_hit_o=0, run resumes.
//  5. period=6, halt_i mid-WAIT with run_i held -> WAIT completes, no further
//     pulses. run_i 1->0->1 -> restarts.
//  6. rst_i during ISSUE -> outputs 0 next cycle. cnt=0xFFFF+issue -> 0.
//     cnt_clr_i with a same-cycle issue -> 0.

Source files
------------

// File: rtl/cpu_exec_sequencer.sv
// Purpose: paces exec_enable_o to the CPU control FSM for run, step, halt and PC breakpoint; counts issues.
// Latency: a go/step decision at one edge raises exec_enable_o for the following cycle; issues are eff_period apart.
// Backpressure: none; halt is deferred until the in-flight issue window closes, and step is ignored while busy.
module cpu_exec_sequencer #(
    parameter int PC_W     = 8,
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                step_i,
    input  logic                halt_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic                bp_en_i,
    input  logic [PC_W-1:0]     bp_addr_i,
    input  logic                cnt_clr_i,
    output logic                exec_enable_o,
    output logic                busy_o,
    output logic                bp_hit_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic                single_q;
    logic                single_d;
    logic                run_q;
    logic                run_arm;
    logic                halt_pend;
    logic [PERIOD_W-1:0] wait_cnt;
    logic [CNT_W-1:0]    instr_cnt;

    logic                run_rise;
    logic                go_run;
    logic                bp_match;
    logic [PERIOD_W-1:0] eff_period;

    assign run_rise   = run_i & ~run_q;
    assign go_run     = run_i & (run_arm | run_rise) & ~halt_i;
    assign bp_match   = bp_en_i & (pc_i == bp_addr_i);
    // Periods below 2 are stretched so every pulse is followed by a low cycle.
    assign eff_period = (period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_i;

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        case (state_q)
            S_IDLE: begin
                if (go_run) begin
                    if (bp_match) begin
                        state_d = S_BREAK;
                    end else begin
                        state_d  = S_ISSUE;
                        single_d = 1'b0;
                    end
                end else if (step_i && !halt_i) begin
                    state_d  = S_ISSUE;
                    single_d = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    if (single_q || halt_pend || !run_arm) begin
                        state_d = S_IDLE;
                    end else if (bp_match) begin
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_BREAK: begin
                if (step_i) begin
                    state_d  = S_ISSUE;
                    single_d = 1'b1;
                end else if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            single_q  <= 1'b0;
            run_q     <= 1'b0;
            run_arm   <= 1'b0;
            halt_pend <= 1'b0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            run_q    <= run_i;

            if (halt_i || !run_i) begin
                run_arm <= 1'b0;
            end else if (run_rise) begin
                run_arm <= 1'b1;
            end

            if (state_d == S_IDLE) begin
                halt_pend <= 1'b0;
            end else if (halt_i && (state_q == S_ISSUE || state_q == S_WAIT)) begin
                halt_pend <= 1'b1;
            end

            // ISSUE itself plus WAIT down to zero spans exactly eff_period cycles.
            if (state_q == S_ISSUE) begin
                wait_cnt <= eff_period - PERIOD_W'(2);
            end else if (state_q == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - PERIOD_W'(1);
            end

            if (cnt_clr_i) begin
                instr_cnt <= '0;
            end else if (state_q == S_ISSUE) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign exec_enable_o = (state_q == S_ISSUE);
    assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bp_hit_o      = (state_q == S_BREAK);
    assign instr_cnt_o   = instr_cnt;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Bench for cpu_exec_sequencer: directed scenarios plus random traffic against a timeline-based model.
module tb_cpu_exec_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        step_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [7:0]  period_i = 8'd2;
    logic [7:0]  pc_i = 8'd0;
    logic        bp_en_i = 1'b0;
    logic [7:0]  bp_addr_i = 8'd0;
    logic        cnt_clr_i = 1'b0;

    logic        exec_enable_o, busy_o, bp_hit_o;
    logic [15:0] instr_cnt_o;
    logic        exec_s, busy_s, bp_s;
    logic [3:0]  cnt_s;
    logic [25:0] obs;

    int total = 0;
    int passed = 0;

    cpu_exec_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .period_i(period_i), .pc_i(pc_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
        .cnt_clr_i(cnt_clr_i), .exec_enable_o(exec_enable_o), .busy_o(busy_o),
        .bp_hit_o(bp_hit_o), .instr_cnt_o(instr_cnt_o)
    );

    // Narrow-counter copy so counter wrap is reachable in a short run.
    cpu_exec_sequencer #(.CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .period_i(period_i), .pc_i(pc_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
        .cnt_clr_i(cnt_clr_i), .exec_enable_o(exec_s), .busy_o(busy_s),
        .bp_hit_o(bp_s), .instr_cnt_o(cnt_s)
    );

    assign obs = {exec_enable_o, busy_o, bp_hit_o, instr_cnt_o, exec_s, busy_s, bp_s, cnt_s};

    always #5 clk_i = ~clk_i;

    // Model: mode 0 idle, 1 busy (issued at m_issue_at, decides at m_dec), 2 break.
    int cyc = 0;
    int m_mode = 0;
    int m_issue_at = -1;
    int m_dec = -1;
    int m_cnt = 0;
    bit m_single = 0, m_halt = 0, m_arm = 0, m_runq = 0;

    function automatic bit exp_exec();
        return (m_mode == 1) && (cyc == m_issue_at);
    endfunction

    function automatic logic [25:0] exp_vec();
        logic e, b, k;
        logic [15:0] c;
        e = exp_exec();
        b = (m_mode == 1);
        k = (m_mode == 2);
        c = m_cnt[15:0];
        return {e, b, k, c, e, b, k, c[3:0]};
    endfunction

    task automatic model_step();
        bit rise, go, bpm, issue_next, issuing;
        int nmode, eff;
        if (rst_i) begin
            m_mode = 0; m_issue_at = -1; m_dec = -1; m_cnt = 0;
            m_single = 0; m_halt = 0; m_arm = 0; m_runq = 0;
            cyc++;
            return;
        end
        rise = run_i && !m_runq;
        go = run_i && (m_arm || rise) && !halt_i;
        bpm = bp_en_i && (pc_i == bp_addr_i);
        issuing = (m_mode == 1) && (cyc == m_issue_at);
        nmode = m_mode;
        issue_next = 0;
        if (m_mode == 0) begin
            if (go) begin
                if (bpm) nmode = 2;
                else begin issue_next = 1; m_single = 0; end
            end else if (step_i && !halt_i) begin
                issue_next = 1; m_single = 1;
            end
        end else if (m_mode == 1) begin
            if (issuing) begin
                eff = (period_i < 2) ? 2 : int'(period_i);
                m_dec = cyc + eff - 1;
            end else if (cyc == m_dec) begin
                if (m_single || m_halt || !m_arm) nmode = 0;
                else if (bpm) nmode = 2;
                else issue_next = 1;
            end
        end else begin
            if (step_i) begin issue_next = 1; m_single = 1; end
            else if (!run_i) nmode = 0;
        end
        if (issue_next) begin
            nmode = 1;
            m_issue_at = cyc + 1;
        end
        if (cnt_clr_i) m_cnt = 0;
        else if (issuing) m_cnt = (m_cnt + 1) & 32'hFFFF;
        if (nmode == 0) m_halt = 0;
        else if (m_mode == 1 && halt_i) m_halt = 1;
        if (halt_i || !run_i) m_arm = 0;
        else if (rise) m_arm = 1;
        m_runq = run_i;
        m_mode = nmode;
        cyc++;
    endtask

    // One clock: model advances with the current inputs, DUT samples at the edge.
    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        step_i = 1'b0;
        halt_i = 1'b0;
        cnt_clr_i = 1'b0;
        if (exp_exec()) pc_i = pc_i + 8'd1;
    endtask

    task automatic go_idle();
        run_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 600 && m_mode != 0; i++) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; run_i = 1'b1; period_i = 8'd4;
        tick();
        tick();
        total++;
        if (obs !== 26'd0) $display("FAIL reset_zero got=%h exp=0", obs); else passed++;
        total++;
        if (obs !== exp_vec()) $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); else passed++;
        rst_i = 1'b0; run_i = 1'b0;
        tick();
    endtask

    task automatic test_run_period4();
        int hits[$];
        period_i = 8'd4;
        run_i = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL run4 cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) hits.push_back(i);
        end
        total++;
        if (hits.size() != 3 || hits[0] != 1 || hits[1] != 5 || hits[2] != 9)
            $display("FAIL run4_pulses got_count=%0d exp pulses at 1,5,9", hits.size());
        else passed++;
        total++;
        if (instr_cnt_o !== 16'd3) $display("FAIL run4_cnt got=%0d exp=3", instr_cnt_o); else passed++;
        go_idle();
    endtask

    task automatic test_short_periods();
        int cnt, first, second;
        bit prev, dbl;
        for (int k = 0; k < 2; k++) begin
            period_i = 8'(k);
            run_i = 1'b1;
            cnt = 0; prev = 0; dbl = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                total++;
                if (obs !== exp_vec()) $display("FAIL short_p%0d got=%h exp=%h", k, obs, exp_vec()); else passed++;
                if (exec_enable_o) begin
                    cnt++;
                    if (prev) dbl = 1;
                end
                prev = exec_enable_o;
            end
            total++;
            if (cnt != 4 || dbl) $display("FAIL short_p%0d_spacing got=%0d pulses dbl=%0d exp=4 dbl=0", k, cnt, dbl);
            else passed++;
            go_idle();
        end
        period_i = 8'd255;
        run_i = 1'b1;
        first = -1; second = -1;
        for (int i = 0; i < 600 && second < 0; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL p255 cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) begin
                if (first < 0) first = i; else second = i;
            end
        end
        total++;
        if (first < 0 || second < 0 || second - first != 255)
            $display("FAIL p255_spacing got=%0d exp=255", second - first);
        else passed++;
        go_idle();
    endtask

    task automatic test_step();
        int pulses, busy_n, base;
        period_i = 8'd5;
        base = m_cnt;
        step_i = 1'b1;
        pulses = 0; busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL step cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) pulses++;
            if (busy_o) busy_n++;
        end
        total++;
        if (pulses != 1 || busy_n != 5) $display("FAIL step_shape got pulses=%0d busy=%0d exp 1 and 5", pulses, busy_n);
        else passed++;
        total++;
        if (instr_cnt_o !== 16'(base + 1)) $display("FAIL step_cnt got=%0d exp=%0d", instr_cnt_o, base + 1); else passed++;
    endtask

    task automatic test_breakpoint();
        int pulses;
        rst_i = 1'b1; run_i = 1'b0;
        tick();
        rst_i = 1'b0;
        pc_i = 8'd0; bp_en_i = 1'b1; bp_addr_i = 8'd3; period_i = 8'd2;
        run_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL bp_run cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) pulses++;
        end
        total++;
        if (pulses != 3 || bp_hit_o !== 1'b1) $display("FAIL bp_stop got pulses=%0d hit=%b exp 3 and 1", pulses, bp_hit_o);
        else passed++;
        step_i = 1'b1;
        tick();
        total++;
        if (exec_enable_o !== 1'b1 || bp_hit_o !== 1'b0)
            $display("FAIL bp_step got exec=%b hit=%b exp 1 and 0", exec_enable_o, bp_hit_o);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL bp_resume cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) pulses++;
        end
        total++;
        if (pulses < 2) $display("FAIL bp_resume_count got=%0d exp>=2", pulses); else passed++;
        go_idle();
        bp_en_i = 1'b0;
    endtask

    task automatic test_halt();
        int pulses;
        period_i = 8'd6;
        run_i = 1'b1;
        tick();
        total++;
        if (exec_enable_o !== 1'b1) $display("FAIL halt_first got=%b exp=1", exec_enable_o); else passed++;
        tick();
        tick();
        halt_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL halt_wait cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) pulses++;
        end
        total++;
        if (pulses != 0 || busy_o !== 1'b0) $display("FAIL halt_stop got pulses=%0d busy=%b exp 0 and 0", pulses, busy_o);
        else passed++;
        run_i = 1'b0;
        tick();
        tick();
        run_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL halt_restart cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
            if (exec_enable_o) pulses++;
        end
        total++;
        if (pulses != 2) $display("FAIL halt_restart_count got=%0d exp=2", pulses); else passed++;
        go_idle();
    endtask

    task automatic test_reset_counter();
        period_i = 8'd2;
        run_i = 1'b1;
        tick();
        total++;
        if (exec_enable_o !== 1'b1) $display("FAIL rst_pre got=%b exp=1", exec_enable_o); else passed++;
        rst_i = 1'b1;
        tick();
        total++;
        if ({exec_enable_o, busy_o, bp_hit_o, instr_cnt_o} !== 19'd0)
            $display("FAIL rst_mid_issue got=%h exp=0", {exec_enable_o, busy_o, bp_hit_o, instr_cnt_o});
        else passed++;
        rst_i = 1'b0;
        tick();
        total++;
        if (exec_enable_o !== 1'b1) $display("FAIL rst_restart got=%b exp=1", exec_enable_o); else passed++;
        tick();
        tick();
        cnt_clr_i = 1'b1;
        tick();
        total++;
        if (instr_cnt_o !== 16'd0) $display("FAIL clr_vs_issue got=%0d exp=0", instr_cnt_o); else passed++;
        for (int i = 0; i < 100 && m_cnt < 16; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL wrap_run cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
        end
        total++;
        if (instr_cnt_o !== 16'd16 || cnt_s !== 4'd0)
            $display("FAIL cnt_wrap got wide=%0d narrow=%0d exp 16 and 0", instr_cnt_o, cnt_s);
        else passed++;
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_i = ~run_i;
            step_i = ($urandom_range(0, 11) == 0);
            halt_i = ($urandom_range(0, 15) == 0);
            cnt_clr_i = ($urandom_range(0, 63) == 0);
            rst_i = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) period_i = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) bp_en_i = ~bp_en_i;
            if ($urandom_range(0, 29) == 0) bp_addr_i = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) pc_i = 8'($urandom_range(0, 15));
            tick();
            total++;
            if (obs !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec()); else passed++;
        end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_period4();
        test_short_periods();
        test_step();
        test_breakpoint();
        test_halt();
        test_reset_counter();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
